// File: rtl/uart_pkg.sv
// uart_pkg: shared arbiter state encoding, UART state-word fields and clog2 helper
package uart_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam int TX_HEAD_LSB = 21;
  localparam int TX_HEAD_W = 7;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: first asserted request at or after ptr, wrapping modulo NREQ
module rr_picker
  import uart_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   win,
  output logic            any
);
  int best, off;
  // keep the request with the smallest rotated distance from ptr
  always_comb begin
    win = '0;
    best = NREQ;
    off = 0;
    for (int j = 0; j < NREQ; j++) begin
      off = (j >= int'(ptr)) ? j - int'(ptr) : j + NREQ - int'(ptr);
      if (req[j] && off < best) begin
        best = off;
        win = IW'(j);
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of the UART TX byte path
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int RING_SIZE_TX = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic [31:0]              uart_state,
  output logic                     uart_we,
  output logic [31:0]              uart_di,
  output logic [clog2(NREQ)-1:0]   grant_id,
  output logic                     busy,
  output logic                     timeout_evt
);
  localparam int IW = clog2(NREQ);
  localparam int SW = (clog2(TIMEOUT) > 0) ? clog2(TIMEOUT) : 1;
  logic [0:0] state_q, state_d;
  logic [IW-1:0] grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d, rr_nx, win;
  logic [RING_SIZE_TX-1:0] head_q, head_d, tail_q, tail_d, fill;
  logic [TX_HEAD_W-1:0] head_f;
  logic [SW-1:0] stall_q, stall_d;
  logic we_q, any, space, v, last, fire, done, unused_state;
  logic [7:0] byte_g;
  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(req_valid), .ptr(rr_ptr_q), .win(win), .any(any)
  );
  assign head_f = uart_state[TX_HEAD_LSB +: TX_HEAD_W];
  assign head_d = head_f[RING_SIZE_TX-1:0];
  assign unused_state = ^{uart_state, head_f};
  // one spare slot, and no back-to-back writes so the registered head can catch up
  assign fill = tail_q - head_q;
  assign space = (fill != '1) && !we_q;
  assign busy = state_q == ST_GRANT;
  assign v = req_valid[grant_id_q];
  assign last = req_last[grant_id_q];
  assign byte_g = req_data[{grant_id_q, 3'b000} +: 8];
  assign fire = busy && v && space;
  assign timeout_evt = busy && !v && stall_q == SW'(TIMEOUT - 1);
  assign uart_we = fire;
  assign uart_di = fire ? {24'b0, byte_g} : '0;
  assign req_ready = (busy && space) ? NREQ'(1) << grant_id_q : '0;
  assign grant_id = grant_id_q;
  // arbitration, packet completion, stall timer and shadow tail
  always_comb begin
    rr_nx = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
    done = (fire && last) || timeout_evt;
    state_d = busy ? (done ? ST_IDLE : ST_GRANT) : (any ? ST_GRANT : ST_IDLE);
    grant_id_d = (!busy && any) ? win : grant_id_q;
    rr_ptr_d = (busy && done) ? rr_nx : rr_ptr_q;
    stall_d = (!busy || fire || done) ? '0 : (!v ? stall_q + 1'b1 : stall_q);
    tail_d = fire ? tail_q + 1'b1 : tail_q;
  end
  // state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_id_q <= '0;
      rr_ptr_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      stall_q <= '0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q <= rr_ptr_d;
      head_q <= head_d;
      tail_q <= tail_d;
      stall_q <= stall_d;
      we_q <= fire;
    end
  end
endmodule
